// File: rtl/run_sequencer.sv
// run_sequencer: multi-cycle run controller for the accumulator core.
// Owns the program counter and steps each instruction through FETCH, EXEC and,
// for loads, MEMWAIT. ExecEn is the single commit strobe that qualifies the
// decoder's write enables.
//
// Ports:
//   Clk, Reset          clock, asynchronous active-high reset
//   Start, StartAddr    run request and entry PC (honoured in IDLE/DONE only)
//   Halt, Branch, BranchTaken, BranchTarget, ReadMem, WriteMem
//                       decoder flags, meaningful during EXEC
//   PC                  current instruction address (registered)
//   InstFetch           instruction ROM / IR load enable
//   ExecEn              one-cycle commit pulse
//   MemReq              data-memory access active
//   Done                program finished, held until next Start
//   CycleCount          active cycles of the current/last run (saturating)
module run_sequencer #(
  parameter int PC_W    = 10,
  parameter int MEM_LAT = 1
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic [PC_W-1:0] StartAddr,
  input  logic            Halt,
  input  logic            Branch,
  input  logic            BranchTaken,
  input  logic [PC_W-1:0] BranchTarget,
  input  logic            ReadMem,
  input  logic            WriteMem,
  output logic [PC_W-1:0] PC,
  output logic            InstFetch,
  output logic            ExecEn,
  output logic            MemReq,
  output logic            Done,
  output logic [15:0]     CycleCount
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_EXEC, S_MEMWAIT, S_DONE
  } state_t;

  // MEMWAIT runs WAIT_INIT+1 cycles, the last of which commits the load.
  localparam logic [1:0] WAIT_INIT = 2'(MEM_LAT - 1);

  state_t          r_state, w_next;
  logic [PC_W-1:0] r_pc, w_pc_next, w_pc_inc;
  logic [1:0]      r_wait, w_wait_next;
  logic [15:0]     r_cycles;
  logic            w_start;
  logic            w_active;

  assign w_pc_inc = r_pc + PC_W'(1);  // wraps modulo 2^PC_W
  assign w_active = (r_state == S_FETCH) || (r_state == S_EXEC) ||
                    (r_state == S_MEMWAIT);

  always_comb begin
    w_next      = r_state;
    w_pc_next   = r_pc;
    w_wait_next = r_wait;
    w_start     = 1'b0;
    InstFetch   = 1'b0;
    ExecEn      = 1'b0;
    MemReq      = 1'b0;
    Done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Start) begin
          w_next    = S_FETCH;
          w_pc_next = StartAddr;
          w_start   = 1'b1;
        end
      end
      S_FETCH: begin
        InstFetch = 1'b1;
        w_next    = S_EXEC;
      end
      S_EXEC: begin
        // Halt > Branch > ReadMem > WriteMem > everything else
        if (Halt) begin
          w_next = S_DONE;
        end else if (Branch) begin
          ExecEn    = 1'b1;
          w_pc_next = BranchTaken ? BranchTarget : w_pc_inc;
          w_next    = S_FETCH;
        end else if (ReadMem) begin
          // Load commits only once data has arrived, at the end of MEMWAIT.
          MemReq      = 1'b1;
          w_wait_next = WAIT_INIT;
          w_next      = S_MEMWAIT;
        end else if (WriteMem) begin
          MemReq    = 1'b1;
          ExecEn    = 1'b1;
          w_pc_next = w_pc_inc;
          w_next    = S_FETCH;
        end else begin
          ExecEn    = 1'b1;
          w_pc_next = w_pc_inc;
          w_next    = S_FETCH;
        end
      end
      S_MEMWAIT: begin
        MemReq = 1'b1;
        if (r_wait != 2'd0) begin
          w_wait_next = r_wait - 2'd1;
        end else begin
          ExecEn    = 1'b1;
          w_pc_next = w_pc_inc;
          w_next    = S_FETCH;
        end
      end
      S_DONE: begin
        Done = 1'b1;
        if (Start) begin
          w_next    = S_FETCH;
          w_pc_next = StartAddr;
          w_start   = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state  <= S_IDLE;
      r_pc     <= '0;
      r_wait   <= 2'd0;
      r_cycles <= 16'd0;
    end else begin
      r_state <= w_next;
      r_pc    <= w_pc_next;
      r_wait  <= w_wait_next;
      if (w_start)
        r_cycles <= 16'd0;
      else if (w_active && (r_cycles != 16'hFFFF))
        r_cycles <= r_cycles + 16'd1;
    end
  end

  assign PC         = r_pc;
  assign CycleCount = r_cycles;

endmodule
